// File: rtl/multicycle_control_32.sv
// Main control FSM for a multicycle MIPS datapath. It sequences the
// FETCH/DECODE/EXECUTE/MEM/WB steps, drives the datapath strobes and the
// alu_op/alu_start pair, and waits on alu_finished with a bounded timeout.
// Optional feature: define ERR_HALT_EN so that ALU error flags seen on the
// finishing cycle of an ALU state halt the FSM in ERROR (code 3 or 4).
module multicycle_control_32 #(
    parameter int ALU_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    input  logic [5:0] opcode,
    input  logic       alu_finished,
    input  logic       alu_err_func,
    input  logic       alu_err_op,
    output logic [1:0] alu_op,
    output logic       alu_start,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic [3:0] state,
    output logic [2:0] err_code
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC     = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ERROR    = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_OPCODE  = 3'd1;
    localparam logic [2:0] ERR_TIMEOUT = 3'd2;
    localparam logic [2:0] ERR_FUNC    = 3'd3;
    localparam logic [2:0] ERR_ALUOP   = 3'd4;

    localparam logic [8:0] TMO = 9'(ALU_TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;     // cycles already spent in the current ALU state
    logic [2:0] err_q, err_d;
    logic [5:0] op_q, op_d;       // opcode captured when DECODE retires

    logic       is_alu;
    logic       first_cyc;
    logic       halt;
    logic [2:0] halt_code;
    logic       exit_ok;
    logic       timeout;

    assign is_alu = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                    (state_q == S_MEM_ADDR) || (state_q == S_EXEC) ||
                    (state_q == S_BRANCH);

    // The entry cycle of an ALU state is the one where the counter is still zero.
    assign first_cyc = is_alu && (cnt_q == 8'd0);

`ifdef ERR_HALT_EN
    // ALU error flags only matter on the cycle the ALU reports completion.
    assign halt      = is_alu && alu_finished && (alu_err_func || alu_err_op);
    assign halt_code = alu_err_func ? ERR_FUNC : ERR_ALUOP;
`else
    logic unused_err;
    assign unused_err = alu_err_func ^ alu_err_op;
    assign halt       = 1'b0;
    assign halt_code  = ERR_NONE;
`endif

    assign exit_ok = is_alu && alu_finished && !halt;
    assign timeout = is_alu && !alu_finished && (({1'b0, cnt_q} + 9'd1) >= TMO);

    // Next-state, wait-counter, sticky error and captured-opcode logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = 8'd0;
        err_d   = err_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) state_d = S_FETCH;
            end
            S_FETCH, S_DECODE, S_MEM_ADDR, S_EXEC, S_BRANCH: begin
                if (halt) begin
                    state_d = S_ERROR;
                    err_d   = halt_code;
                end else if (alu_finished) begin
                    case (state_q)
                        S_FETCH: state_d = S_DECODE;
                        S_DECODE: begin
                            op_d = opcode;
                            case (opcode)
                                OP_LW, OP_SW: state_d = S_MEM_ADDR;
                                OP_RTYPE:     state_d = S_EXEC;
                                OP_BEQ:       state_d = S_BRANCH;
                                OP_J:         state_d = S_JUMP;
                                default: begin
                                    state_d = S_ERROR;
                                    err_d   = ERR_OPCODE;
                                end
                            endcase
                        end
                        S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
                        S_EXEC:     state_d = S_R_WB;
                        default:    state_d = S_IDLE;
                    endcase
                end else if (timeout) begin
                    state_d = S_ERROR;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_MEM_RD: state_d = S_MEM_WB;
            S_MEM_WB, S_MEM_WR, S_R_WB, S_JUMP: state_d = S_IDLE;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    // State and bookkeeping registers; reset abandons any instruction at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            err_q   <= ERR_NONE;
            op_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            op_q    <= op_d;
        end
    end

    // Output decode from the state, entry flag and the ALU completion handshake.
    always_comb begin
        alu_op        = 2'b00;
        alu_start     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_start = first_cyc;
                alu_src_b = 2'b01;
                mem_read  = 1'b1;
                if (exit_ok) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            S_DECODE: begin
                alu_start = first_cyc;
                alu_src_b = 2'b11;
            end
            S_MEM_ADDR: begin
                alu_start = first_cyc;
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = 1'b1;
            end
            S_EXEC: begin
                alu_start = first_cyc;
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_start = first_cyc;
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                if (exit_ok) begin
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    instr_done    = 1'b1;
                end
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign state    = state_q;
    assign err_code = err_q;

endmodule

// File: tb/tb_multicycle_control_32.sv
// Self-checking bench for multicycle_control_32: randomized instruction
// streams with random ALU completion delays, timeouts and ALU error flags,
// checked every cycle against a phase-table reference model.
module tb_multicycle_control_32;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       instr_valid = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       alu_finished = 1'b0;
    logic       alu_err_func = 1'b0;
    logic       alu_err_op = 1'b0;
    logic [1:0] alu_op;
    logic       alu_start;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       instr_done;
    logic [3:0] state;
    logic [2:0] err_code;

    int n_chk = 0;
    int n_err = 0;

    multicycle_control_32 #(.ALU_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode),
        .alu_finished(alu_finished), .alu_err_func(alu_err_func), .alu_err_op(alu_err_op),
        .alu_op(alu_op), .alu_start(alu_start), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .pc_source(pc_source), .instr_done(instr_done),
        .state(state), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] aop;
        logic       st;
        logic       sa;
        logic [1:0] sb;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       irw;
        logic       m2r;
        logic       rd;
        logic       rw;
        logic       pcw;
        logic       pcwc;
        logic [1:0] pcs;
        logic       done;
        logic [3:0] state;
        logic [2:0] ec;
    } ov_t;

    ov_t obs;
    assign obs = {alu_op, alu_start, alu_src_a, alu_src_b, i_or_d, mem_read, mem_write,
                  ir_write, mem_to_reg, reg_dst, reg_write, pc_write, pc_write_cond,
                  pc_source, instr_done, state, err_code};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Level outputs each phase presents for its whole duration.
    function automatic ov_t sel(input logic [3:0] st);
        ov_t e;
        e = '0;
        e.state = st;
        case (st)
            4'd1:  begin e.sb = 2'b01; e.mr = 1'b1; end
            4'd2:  begin e.sb = 2'b11; end
            4'd3:  begin e.sa = 1'b1; e.sb = 2'b10; end
            4'd4:  begin e.mr = 1'b1; e.iord = 1'b1; end
            4'd5:  begin e.rw = 1'b1; e.m2r = 1'b1; e.done = 1'b1; end
            4'd6:  begin e.mw = 1'b1; e.iord = 1'b1; e.done = 1'b1; end
            4'd7:  begin e.sa = 1'b1; e.aop = 2'b10; end
            4'd8:  begin e.rw = 1'b1; e.rd = 1'b1; e.done = 1'b1; end
            4'd9:  begin e.sa = 1'b1; e.aop = 2'b01; end
            4'd10: begin e.pcw = 1'b1; e.pcs = 2'b10; e.done = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic bit legal(input logic [5:0] op);
        return (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
               (op == 6'b000100) || (op == 6'b000010);
    endfunction

    // Check at the falling edge, then move to just past the next rising edge.
    task automatic cyc(input ov_t e, input string tag);
        @(negedge clk);
        check(tag, 32'(obs), 32'(e));
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        alu_finished = 1'($urandom);
        alu_err_func = 1'($urandom);
        alu_err_op   = 1'($urandom);
        opcode       = 6'($urandom);
        instr_valid  = 1'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_async", 32'(obs), 32'(0));
        @(negedge clk);
        check("rst_held", 32'(obs), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        instr_valid = 1'b0;
        alu_finished = 1'b0;
    endtask

    // One ALU phase: finished arrives in cycle d (d > TMO means never).
    // outcome: 0 normal exit, otherwise the expected error code.
    task automatic alu_phase(input logic [3:0] st, input int d, input bit ef, input bit eo,
                             input logic [5:0] opc, output int outcome);
        int  lim;
        bit  hlt;
        ov_t e;
        lim = (d > TMO) ? TMO : d;
        hlt = 1'b0;
`ifdef ERR_HALT_EN
        hlt = ef | eo;
`endif
        for (int c = 1; c <= lim; c++) begin
            scramble();
            alu_finished = (c == d);
            if (c == d) begin
                alu_err_func = ef;
                alu_err_op   = eo;
            end
            if (st == 4'd2) opcode = opc;
            e = sel(st);
            e.st = (c == 1);
            if (c == d && !hlt) begin
                if (st == 4'd1) begin e.irw = 1'b1; e.pcw = 1'b1; end
                if (st == 4'd9) begin e.pcwc = 1'b1; e.pcs = 2'b01; e.done = 1'b1; end
            end
            cyc(e, $sformatf("alu_st%0d_c%0d", st, c));
        end
        if (d > TMO)                        outcome = 2;
        else if (hlt)                       outcome = ef ? 3 : 4;
        else if (st == 4'd2 && !legal(opc)) outcome = 1;
        else                                outcome = 0;
    endtask

    task automatic error_hold(input int code);
        ov_t e;
        e = '0;
        e.state = 4'd15;
        e.ec = 3'(code);
        for (int k = 0; k < 3; k++) begin
            scramble();
            instr_valid = 1'b1;
            cyc(e, "err_hold");
        end
        do_reset();
    endtask

    task automatic one_cycle(input logic [3:0] st);
        scramble();
        cyc(sel(st), $sformatf("st%0d", st));
    endtask

    // Runs one instruction from IDLE; erridx selects which ALU phase sees the error flags.
    task automatic run_instr(input logic [5:0] opc, input int d0, input int d1, input int d2,
                             input int erridx, input bit ef, input bit eo);
        int nidle;
        int res;
        logic [3:0] third;
        nidle = $urandom_range(0, 2);
        for (int k = 0; k < nidle; k++) begin
            scramble();
            instr_valid = 1'b0;
            cyc(sel(4'd0), "idle_wait");
        end
        scramble();
        instr_valid = 1'b1;
        cyc(sel(4'd0), "idle_go");
        instr_valid = 1'b0;
        alu_phase(4'd1, d0, erridx == 0 && ef, erridx == 0 && eo, opc, res);
        if (res != 0) begin error_hold(res); return; end
        alu_phase(4'd2, d1, erridx == 1 && ef, erridx == 1 && eo, opc, res);
        if (res != 0) begin error_hold(res); return; end
        if (opc == 6'b000010) begin
            one_cycle(4'd10);
            return;
        end
        third = (opc == 6'b000000) ? 4'd7 : (opc == 6'b000100) ? 4'd9 : 4'd3;
        alu_phase(third, d2, erridx == 2 && ef, erridx == 2 && eo, opc, res);
        if (res != 0) begin error_hold(res); return; end
        case (opc)
            6'b100011: begin one_cycle(4'd4); one_cycle(4'd5); end
            6'b101011: one_cycle(4'd6);
            6'b000000: one_cycle(4'd8);
            default: ;
        endcase
    endtask

    function automatic int rnd_delay();
        return ($urandom_range(0, 9) == 0) ? TMO + 1 : int'($urandom_range(1, TMO));
    endfunction

    initial begin
        ov_t e;
        logic [5:0] opc;
        int r;
        int eidx;
        rst = 1'b1;
        #1;
        check("reset_state", 32'(obs), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed: R-type with immediate completion, lw with slow ALU.
        run_instr(6'b000000, 1, 1, 1, -1, 1'b0, 1'b0);
        run_instr(6'b100011, 3, 3, 3, -1, 1'b0, 1'b0);
        run_instr(6'b101011, 1, 2, TMO, -1, 1'b0, 1'b0);
        run_instr(6'b000100, 1, 1, 2, -1, 1'b0, 1'b0);
        run_instr(6'b000010, 2, 1, 1, -1, 1'b0, 1'b0);
        // Illegal opcode, FETCH timeout, ALU func error on EXEC finish.
        run_instr(6'b111111, 1, 1, 1, -1, 1'b0, 1'b0);
        run_instr(6'b000000, TMO + 1, 1, 1, -1, 1'b0, 1'b0);
        run_instr(6'b000000, 1, 1, 1, 2, 1'b1, 1'b1);
        run_instr(6'b000000, 1, 1, 1, 2, 1'b0, 1'b1);

        // Reset arriving in the middle of EXEC must drop everything at once.
        scramble();
        instr_valid = 1'b1;
        cyc(sel(4'd0), "mid_idle");
        alu_finished = 1'b1; alu_err_func = 1'b0; alu_err_op = 1'b0; opcode = 6'd0;
        e = sel(4'd1); e.st = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
        cyc(e, "mid_fetch");
        alu_finished = 1'b1; opcode = 6'd0;
        e = sel(4'd2); e.st = 1'b1;
        cyc(e, "mid_decode");
        alu_finished = 1'b0;
        e = sel(4'd7); e.st = 1'b1;
        cyc(e, "mid_exec");
        do_reset();

        // Randomized instruction stream.
        for (int n = 0; n < 120; n++) begin
            r = $urandom_range(0, 5);
            case (r)
                0: opc = 6'b100011;
                1: opc = 6'b101011;
                2: opc = 6'b000000;
                3: opc = 6'b000100;
                4: opc = 6'b000010;
                default: opc = 6'($urandom);
            endcase
            eidx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2)) : -1;
            run_instr(opc, rnd_delay(), rnd_delay(), rnd_delay(), eidx,
                      1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
